// File: rtl/mux_5to1_arbiter_if.sv
// rtl/mux_5to1_arbiter_if.sv - request/grant bundle between the five operand producers, the arbiter and the shared mux stage
interface mux_5to1_arbiter_if;
  logic [4:0] req;
  logic [4:0] last;
  logic       out_rdy;
  logic [2:0] mux_sel;
  logic       mux_val;
  logic [4:0] gnt;
  logic       locked;

  modport master (
    output req, last, out_rdy,
    input  mux_sel, mux_val, gnt, locked
  );

  modport slave (
    input  req, last, out_rdy,
    output mux_sel, mux_val, gnt, locked
  );
endinterface

// File: rtl/mux_5to1_arbiter.sv
// rtl/mux_5to1_arbiter.sv - round-robin 5-to-1 lane arbiter; define MUX5_ARB_LOCK_EN for packet lock with MAX_BURST limit
module mux_5to1_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = $clog2(MAX_BURST)
) (
  input  logic              clk,
  input  logic              reset,
  mux_5to1_arbiter_if.slave bus
);

  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [2:0] cand;
  logic [2:0] rr_idx;
  logic       rr_ok;
  logic [2:0] win_idx;
  logic       win_ok;
  logic       fire;

  // Walk the search order backwards so the earliest index after ptr is the last to land.
  always_comb begin
    rr_ok  = 1'b0;
    rr_idx = 3'd0;
    cand   = 3'd0;
    for (int k = 5; k >= 1; k--) begin
      cand = 3'((int'(ptr) + k) % 5);
      if (bus.req[cand]) begin
        rr_ok  = 1'b1;
        rr_idx = cand;
      end
    end
  end

`ifdef MUX5_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCK} st_t;

  st_t              st;
  st_t              st_nxt;
  logic [2:0]       owner;
  logic [2:0]       owner_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // While locked, only the owner may use the lane, even if it pauses mid-packet.
  always_comb begin
    win_ok  = rr_ok;
    win_idx = rr_idx;
    if (st == LOCK) begin
      win_ok  = bus.req[owner];
      win_idx = bus.req[owner] ? owner : 3'd0;
    end
  end

  always_comb begin
    st_nxt    = st;
    owner_nxt = owner;
    cnt_nxt   = beat_cnt;
    ptr_nxt   = ptr;
    if (fire) begin
      ptr_nxt = win_idx;
      if (bus.last[win_idx] || (beat_cnt == CNT_W'(MAX_BURST - 1))) begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
      end else begin
        st_nxt    = LOCK;
        owner_nxt = win_idx;
        cnt_nxt   = beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      owner    <= 3'd0;
      beat_cnt <= '0;
      ptr      <= 3'd4;
    end else begin
      st       <= st_nxt;
      owner    <= owner_nxt;
      beat_cnt <= cnt_nxt;
      ptr      <= ptr_nxt;
    end
  end

  assign bus.locked = ~reset & (st == LOCK);
`else
  logic unused_cfg;

  assign win_ok     = rr_ok;
  assign win_idx    = rr_idx;
  assign ptr_nxt    = fire ? win_idx : ptr;
  assign bus.locked = 1'b0;
  assign unused_cfg = (^bus.last) ^ MAX_BURST[0] ^ CNT_W[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 3'd4;
    end else begin
      ptr <= ptr_nxt;
    end
  end
`endif

  assign fire        = win_ok & bus.out_rdy & ~reset;
  assign bus.mux_val = win_ok & ~reset;
  assign bus.mux_sel = reset ? 3'd0 : win_idx;
  assign bus.gnt     = fire ? 5'(5'd1 << win_idx) : 5'd0;

endmodule

// File: tb/tb_mux_5to1_arbiter.sv
// tb/tb_mux_5to1_arbiter.sv - scoreboard bench for mux_5to1_arbiter, both builds (MUX5_ARB_LOCK_EN)
module tb_mux_5to1_arbiter;
  localparam int MB = 4;
`ifdef MUX5_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] sel;
    logic       val;
    logic [4:0] gnt;
    logic       locked;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got;
  exp_t want;

  mux_5to1_arbiter_if bus();

  mux_5to1_arbiter #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input int sel, input bit val, input bit g, input bit lk);
    exp_t e;
    e.sel    = 3'(sel);
    e.val    = val;
    e.gnt    = g ? 5'(1 << sel) : 5'd0;
    e.locked = lk;
    return e;
  endfunction

  task automatic apply(input logic rst, input logic [4:0] r, input logic [4:0] l, input logic rdy);
    @(posedge clk);
    #1;
    reset       = rst;
    bus.req     = r;
    bus.last    = l;
    bus.out_rdy = rdy;
  endtask

  task automatic do_reset();
    apply(1'b1, 5'd0, 5'd0, 1'b0);
    apply(1'b1, 5'd0, 5'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (bus.mux_sel > 3'd4 || !$onehot0(bus.gnt) || (bus.gnt != 5'd0 && !bus.mux_val)) begin
        errors++;
        $display("FAIL invariant: sel=%0d gnt=%b val=%b, required sel<=4 and gnt one-hot/zero", bus.mux_sel, bus.gnt, bus.mux_val);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(i < 2, 5'b11111, 5'b11111, 1'b1);
      sb.push_back(i < 2 ? ex(0, 0, 0, 0) : ex(0, 1, 1, 0));
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 5'b11111, 5'b11111, 1'b1);
      sb.push_back(ex(i % 5, 1, 1, 0));
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL round_robin step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_rdy_toggle();
    int       sel_t[4] = '{2, 4, 4, 2};
    bit [3:0] rdy_t    = 4'b0101;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 5'b10100, 5'b11111, rdy_t[i]);
      sb.push_back(ex(sel_t[i], 1, rdy_t[i], 0));
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rdy_toggle step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

`ifdef MUX5_ARB_LOCK_EN
  task automatic test_lock_last();
    logic [4:0] last_t[4] = '{5'b00000, 5'b00000, 5'b00001, 5'b00010};
    int         sel_t[4]  = '{0, 0, 0, 1};
    bit [3:0]   lk_t      = 4'b0110;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 5'b00011, last_t[i], 1'b1);
      sb.push_back(ex(sel_t[i], 1, 1, lk_t[i]));
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL lock_last step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_burst_limit();
    int       sel_t[7] = '{2, 2, 2, 2, 3, 2, 2};
    bit [6:0] lk_t     = 7'b1001110;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 5'b01100, 5'b01000, 1'b1);
      sb.push_back(ex(sel_t[i], 1, 1, lk_t[i]));
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL burst_limit step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_owner_drop();
    logic [4:0] req_t[7]  = '{5'b00010, 5'b00011, 5'b00001, 5'b00001, 5'b00001, 5'b00011, 5'b00011};
    logic [4:0] last_t[7] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00001};
    int         sel_t[7]  = '{1, 1, 0, 0, 0, 1, 0};
    bit [6:0]   val_t     = 7'b1100011;
    bit [6:0]   lk_t      = 7'b0111110;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, req_t[i], last_t[i], 1'b1);
      sb.push_back(ex(sel_t[i], val_t[i], val_t[i], lk_t[i]));
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL owner_drop step %0d: got %h want %h", i, got, want);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin apply(1'b0, 5'b00100, 5'b00000, 1'b1); sb.push_back(ex(2, 1, 1, 0)); end
        1: begin apply(1'b0, 5'b00100, 5'b00000, 1'b1); sb.push_back(ex(2, 1, 1, LOCK_EN)); end
        2: begin apply(1'b1, 5'b00100, 5'b00000, 1'b1); sb.push_back(ex(0, 0, 0, 0)); end
        default: begin apply(1'b0, 5'b11111, 5'b00000, 1'b1); sb.push_back(ex(0, 1, 1, 0)); end
      endcase
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_packet step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_random();
    bit         m_st    = 1'b0;
    int         m_ptr   = 4;
    int         m_owner = 0;
    int         m_cnt   = 0;
    int         w;
    bit         f;
    logic [4:0] r;
    logic [4:0] l;
    logic       rdy;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r   = 5'($urandom_range(0, 31));
      l   = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      rdy = ($urandom_range(0, 3) != 0);
      apply(1'b0, r, l, rdy);
      w = -1;
      if (LOCK_EN && m_st) begin
        if (r[m_owner]) w = m_owner;
      end else begin
        for (int k = 1; k <= 5; k++) begin
          int c = (m_ptr + k) % 5;
          if (w < 0 && r[c]) w = c;
        end
      end
      f = (w >= 0) && rdy;
      sb.push_back(ex(w < 0 ? 0 : w, w >= 0, f, LOCK_EN && m_st));
      if (f) begin
        m_ptr = w;
        if (LOCK_EN) begin
          if (l[w] || m_cnt == MB - 1) begin
            m_st  = 1'b0;
            m_cnt = 0;
          end else begin
            m_st    = 1'b1;
            m_owner = w;
            m_cnt++;
          end
        end
      end
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.mux_sel, bus.mux_val, bus.gnt, bus.locked};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random step %0d: req=%b last=%b rdy=%b got %h want %h", i, r, l, rdy, got, want);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.req     = 5'd0;
    bus.last    = 5'd0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_round_robin();
    test_rdy_toggle();
`ifdef MUX5_ARB_LOCK_EN
    test_lock_last();
    test_burst_limit();
    test_owner_drop();
`endif
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
